// File: rtl/conv_1x1_out_packer.sv
// Output packer for the 1x1 convolution unit. Buffers the result stream in a
// small FIFO, counts beats against a programmed frame length, marks the final
// beat with m_last and pulses write_done once the DMA has taken that beat.
module conv_1x1_out_packer #(
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  beat_total,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  write_done,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] total_q;
  logic [LEN_WIDTH-1:0] in_cnt_q;
  logic [LEN_WIDTH-1:0] out_cnt_q;

  // A start that lands while write_done is high is held here and taken in IDLE.
  logic                 pend_q;
  logic [LEN_WIDTH-1:0] pend_total_q;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic                 push, pop;
  logic                 accept;
  logic [LEN_WIDTH-1:0] accept_total;

  // Handshake flags derive only from registered state so s_ready never
  // depends on s_valid or m_ready.
  assign s_ready    = (state_q == S_RUN) && (in_cnt_q != total_q)
                      && (count_q < CNT_W'(FIFO_DEPTH));
  assign m_valid    = (state_q != S_IDLE) && (count_q != '0);
  assign m_data     = m_valid ? mem[rd_ptr_q] : '0;
  assign m_last     = m_valid && (out_cnt_q == total_q - LEN_WIDTH'(1));
  assign write_done = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);

  assign push         = s_valid && s_ready;
  assign pop          = m_valid && m_ready;
  assign accept       = (state_q == S_IDLE) && (start || pend_q);
  assign accept_total = pend_q ? pend_total_q : beat_total;

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = (accept_total == '0) ? S_DONE : S_RUN;
      S_RUN:  if (pop && m_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Frame length and beat counters; equality compares only, so no wrap logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else if (accept) begin
      total_q   <= accept_total;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (push) in_cnt_q  <= in_cnt_q + LEN_WIDTH'(1);
      if (pop)  out_cnt_q <= out_cnt_q + LEN_WIDTH'(1);
    end
  end

  // Capture a start issued during the write_done cycle for the following IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= 1'b0;
      pend_total_q <= '0;
    end else if (state_q == S_DONE && start) begin
      pend_q       <= 1'b1;
      pend_total_q <= beat_total;
    end else if (accept) begin
      pend_q       <= 1'b0;
    end
  end

  // FIFO storage write port.
  // NOTE: the data array is deliberately not reset; pointers and count define
  // which entries are valid, so clearing the storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
